systolic_mx_matmul_os: RTL and testbench

Next-generation MX-integer systolic matmul. It uses a true output-stationary PE grid: registered east/south operand forwarding, skewed block injection and per-PE accumulators. It accepts one tile (PE_rows rows of A, PE_cols columns of B, vec_elem_count deep, one shared scale per k-element block) over a valid/ready handshake and returns a PE_rows x PE_cols integer result tile. Its new feature over the combinational-replication array is optional accumulation across successive tiles, for K-splitting.

---
 rtl/systolic_mx_matmul_os.sv | 248 ++++++++++++++++++++++++
 tb/tb_systolic_mx_matmul_os.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mx_matmul_os.sv
// Output-stationary MX-integer systolic matmul with per-PE accumulators
// and optional accumulation across successive tiles for K-splitting.
module systolic_mx_matmul_os #(
  parameter int PE_rows        = 2,
  parameter int PE_cols        = 2,
  parameter int vec_elem_count = 8,
  parameter int k              = 2,
  parameter int bit_width      = 8,
  parameter int scale_width    = 8,
  parameter int scale_bias     = 127,
  parameter int acc_width      = 32,
  parameter int out_width      = 16,
  localparam int block_count   = vec_elem_count / k
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  output logic o_ready,
  input  logic i_acc,
  input  logic [PE_rows-1:0][vec_elem_count-1:0][bit_width-1:0] A_i,
  input  logic [PE_rows-1:0][block_count-1:0][scale_width-1:0] S_A_i,
  input  logic [vec_elem_count-1:0][PE_cols-1:0][bit_width-1:0] B_i,
  input  logic [block_count-1:0][PE_cols-1:0][scale_width-1:0] S_B_i,
  output logic o_valid,
  input  logic i_ready,
  output logic [PE_rows-1:0][PE_cols-1:0][out_width-1:0] C_o,
  output logic [PE_rows-1:0][PE_cols-1:0] o_sat
);

  localparam int last_t = block_count + PE_rows + PE_cols - 1;
  localparam int tw     = $clog2(last_t + 1);
  localparam int pw     = 2 * bit_width + $clog2(k) + 1;
  localparam int shw    = scale_width + 2;

  localparam logic signed [acc_width-1:0] sat_hi =
    {{(acc_width-out_width+1){1'b0}}, {(out_width-1){1'b1}}};
  localparam logic signed [acc_width-1:0] sat_lo = ~sat_hi;

  typedef logic [k-1:0][bit_width-1:0] blk_t;
  typedef logic [scale_width-1:0] scl_t;
  typedef enum logic [1:0] {IDLE, FEED, DONE} state_t;

  state_t state, state_nx;
  logic [tw-1:0] t;
  logic accept, feed_end;

  logic [PE_rows-1:0][vec_elem_count-1:0][bit_width-1:0] a_buf;
  logic [PE_rows-1:0][block_count-1:0][scale_width-1:0] sa_buf;
  logic [vec_elem_count-1:0][PE_cols-1:0][bit_width-1:0] b_buf;
  logic [block_count-1:0][PE_cols-1:0][scale_width-1:0] sb_buf;

  blk_t a_inj_d [PE_rows];
  scl_t a_inj_s [PE_rows];
  logic a_inj_v [PE_rows];
  blk_t b_inj_d [PE_cols];
  scl_t b_inj_s [PE_cols];
  logic b_inj_v [PE_cols];

  blk_t a_q_d [PE_rows][PE_cols];
  scl_t a_q_s [PE_rows][PE_cols];
  logic a_q_v [PE_rows][PE_cols];
  blk_t b_q_d [PE_rows][PE_cols];
  scl_t b_q_s [PE_rows][PE_cols];
  logic b_q_v [PE_rows][PE_cols];

  logic signed [acc_width-1:0] term [PE_rows][PE_cols];
  logic signed [acc_width-1:0] acc  [PE_rows][PE_cols];

  function automatic logic signed [acc_width-1:0] mx_term(
    input blk_t a,
    input blk_t b,
    input scl_t sa,
    input scl_t sb
  );
    logic signed [2*bit_width-1:0] pr;
    logic signed [pw-1:0] p;
    logic signed [shw-1:0] sh;
    logic [shw-1:0] mag;
    logic signed [acc_width-1:0] pe;
    p = '0;
    for (int m = 0; m < k; m++) begin
      pr = $signed(a[m]) * $signed(b[m]);
      p  = p + pw'(pr);
    end
    sh  = $signed({2'b00, sa}) + $signed({2'b00, sb})
        - shw'(2 * scale_bias);
    mag = sh[shw-1] ? shw'(-sh) : shw'(sh);
    pe  = acc_width'(p);
    // Shifting fully out of the accumulator gives zero in both directions
    if (32'(mag) >= acc_width) mx_term = '0;
    else if (sh[shw-1])        mx_term = pe >>> mag;
    else                       mx_term = pe <<< mag;
  endfunction

  assign accept   = i_valid && o_ready;
  assign feed_end = (state == FEED) && (t == tw'(last_t));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = FEED;
      end
      FEED: if (feed_end) state_nx = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t      <= '0;
      a_buf  <= '0;
      sa_buf <= '0;
      b_buf  <= '0;
      sb_buf <= '0;
    end else if (accept) begin
      t      <= '0;
      a_buf  <= A_i;
      sa_buf <= S_A_i;
      b_buf  <= B_i;
      sb_buf <= S_B_i;
    end else if (state == FEED) begin
      t <= t + tw'(1);
    end
  end

  // Skewed injection: row i / column j take block b at t = b+i / b+j
  always_comb begin
    for (int i = 0; i < PE_rows; i++) begin
      a_inj_d[i] = '0;
      a_inj_s[i] = '0;
      a_inj_v[i] = 1'b0;
      for (int b = 0; b < block_count; b++)
        if (state == FEED && int'(t) == b + i) begin
          a_inj_v[i] = 1'b1;
          a_inj_s[i] = sa_buf[i][b];
          for (int m = 0; m < k; m++)
            a_inj_d[i][m] = a_buf[i][b*k+m];
        end
    end
    for (int j = 0; j < PE_cols; j++) begin
      b_inj_d[j] = '0;
      b_inj_s[j] = '0;
      b_inj_v[j] = 1'b0;
      for (int b = 0; b < block_count; b++)
        if (state == FEED && int'(t) == b + j) begin
          b_inj_v[j] = 1'b1;
          b_inj_s[j] = sb_buf[b][j];
          for (int m = 0; m < k; m++)
            b_inj_d[j][m] = b_buf[b*k+m][j];
        end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PE_rows; i++)
        for (int j = 0; j < PE_cols; j++) begin
          a_q_d[i][j] <= '0;
          a_q_s[i][j] <= '0;
          a_q_v[i][j] <= 1'b0;
          b_q_d[i][j] <= '0;
          b_q_s[i][j] <= '0;
          b_q_v[i][j] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < PE_rows; i++) begin
        a_q_d[i][0] <= a_inj_d[i];
        a_q_s[i][0] <= a_inj_s[i];
        a_q_v[i][0] <= a_inj_v[i];
        for (int j = 1; j < PE_cols; j++) begin
          a_q_d[i][j] <= a_q_d[i][j-1];
          a_q_s[i][j] <= a_q_s[i][j-1];
          a_q_v[i][j] <= a_q_v[i][j-1];
        end
      end
      for (int j = 0; j < PE_cols; j++) begin
        b_q_d[0][j] <= b_inj_d[j];
        b_q_s[0][j] <= b_inj_s[j];
        b_q_v[0][j] <= b_inj_v[j];
        for (int i = 1; i < PE_rows; i++) begin
          b_q_d[i][j] <= b_q_d[i-1][j];
          b_q_s[i][j] <= b_q_s[i-1][j];
          b_q_v[i][j] <= b_q_v[i-1][j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < PE_rows; i++)
      for (int j = 0; j < PE_cols; j++)
        term[i][j] = mx_term(a_q_d[i][j], b_q_d[i][j],
                             a_q_s[i][j], b_q_s[i][j]);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PE_rows; i++)
        for (int j = 0; j < PE_cols; j++)
          acc[i][j] <= '0;
    end else begin
      for (int i = 0; i < PE_rows; i++)
        for (int j = 0; j < PE_cols; j++)
          if (accept && !i_acc)
            acc[i][j] <= '0;
          else if (a_q_v[i][j] && b_q_v[i][j])
            acc[i][j] <= acc[i][j] + term[i][j];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      C_o   <= '0;
      o_sat <= '0;
    end else if (feed_end) begin
      for (int i = 0; i < PE_rows; i++)
        for (int j = 0; j < PE_cols; j++)
          unique case (1'b1)
            acc[i][j] > sat_hi: begin
              C_o[i][j]   <= sat_hi[out_width-1:0];
              o_sat[i][j] <= 1'b1;
            end
            acc[i][j] < sat_lo: begin
              C_o[i][j]   <= sat_lo[out_width-1:0];
              o_sat[i][j] <= 1'b1;
            end
            default: begin
              C_o[i][j]   <= acc[i][j][out_width-1:0];
              o_sat[i][j] <= 1'b0;
            end
          endcase
    end
  end

endmodule

// File: tb/tb_systolic_mx_matmul_os.sv
// Directed bench for systolic_mx_matmul_os: array-level reference model,
// per-cycle result comparator and hand-computed literal expectations.
module tb_systolic_mx_matmul_os;

  localparam int R  = 2;
  localparam int C  = 2;
  localparam int N  = 8;
  localparam int K  = 2;
  localparam int BC = N / K;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;
  logic i_acc = 1'b0;
  logic o_ready, o_valid;
  logic [R-1:0][N-1:0][7:0]  A;
  logic [R-1:0][BC-1:0][7:0] SA;
  logic [N-1:0][C-1:0][7:0]  B;
  logic [BC-1:0][C-1:0][7:0] SB;
  logic [R-1:0][C-1:0][15:0] C_o;
  logic [R-1:0][C-1:0]       o_sat;

  int   macc  [R][C];
  int   exp_c [R][C];
  logic exp_s [R][C];
  logic exp_ok = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  systolic_mx_matmul_os dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_acc  (i_acc),
    .A_i    (A),
    .S_A_i  (SA),
    .B_i    (B),
    .S_B_i  (SB),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .C_o    (C_o),
    .o_sat  (o_sat)
  );

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  task automatic set_tile(input int av, input int bv,
                          input int sa, input int sb);
    for (int i = 0; i < R; i++)
      for (int e = 0; e < N; e++) A[i][e] = 8'(av);
    for (int e = 0; e < N; e++)
      for (int j = 0; j < C; j++) B[e][j] = 8'(bv);
    for (int i = 0; i < R; i++)
      for (int b = 0; b < BC; b++) SA[i][b] = 8'(sa);
    for (int b = 0; b < BC; b++)
      for (int j = 0; j < C; j++) SB[b][j] = 8'(sb);
  endtask

  task automatic set_mixed(input int seed);
    for (int i = 0; i < R; i++)
      for (int e = 0; e < N; e++) A[i][e] = 8'(e - 3 + 2 * i + seed);
    for (int e = 0; e < N; e++)
      for (int j = 0; j < C; j++) B[e][j] = 8'(3 * j - e + 1 - seed);
    for (int i = 0; i < R; i++)
      for (int b = 0; b < BC; b++) SA[i][b] = 8'(125 + b + i);
    for (int b = 0; b < BC; b++)
      for (int j = 0; j < C; j++) SB[b][j] = 8'(127 + (b + j + seed) % 2);
  endtask

  // Dot product per block, scaled by 2^(SA+SB-254), summed mod 2^32
  task automatic model_accept(input logic accb);
    longint p;
    int sh, term;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        if (!accb) macc[i][j] = 0;
        for (int b = 0; b < BC; b++) begin
          p = 0;
          for (int m = 0; m < K; m++)
            p += longint'($signed(A[i][b*K+m])) *
                 longint'($signed(B[b*K+m][j]));
          sh = int'(SA[i][b]) + int'(SB[b][j]) - 254;
          if (sh >= 32 || sh <= -32) term = 0;
          else if (sh >= 0)          term = int'(p <<< sh);
          else                       term = int'(p >>> (-sh));
          macc[i][j] += term;
        end
        if (macc[i][j] > 32767) begin
          exp_c[i][j] = 32767;  exp_s[i][j] = 1'b1;
        end else if (macc[i][j] < -32768) begin
          exp_c[i][j] = -32768; exp_s[i][j] = 1'b1;
        end else begin
          exp_c[i][j] = macc[i][j]; exp_s[i][j] = 1'b0;
        end
      end
    exp_ok = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (exp_ok) begin
        for (int i = 0; i < R; i++)
          for (int j = 0; j < C; j++) begin
            check($sformatf("c_o[%0d][%0d]", i, j),
                  $signed(C_o[i][j]), exp_c[i][j]);
            check($sformatf("o_sat[%0d][%0d]", i, j),
                  o_sat[i][j], exp_s[i][j]);
          end
        check("ready_in_done", o_ready, 0);
      end else begin
        check("spurious_valid", o_valid, 0);
      end
    end
  end

  task automatic start_tile(input logic accb);
    int n;
    n = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_acc   = accb;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", o_ready, 1);
    @(posedge clk);
    model_accept(accb);
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1 n++;
      if (o_valid) break;
      check("feed_ready_low", o_ready, 0);
    end
    check("latency", n, 8);
  endtask

  task automatic finish_result(input int hold);
    repeat (hold) @(negedge clk);
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1 check("valid_drop", o_valid, 0);
    i_ready = 1'b0;
  endtask

  task automatic run_tile(input logic accb, input bit has_lit,
                          input int lit00, input int lit11);
    start_tile(accb);
    wait_result();
    if (has_lit) begin
      check("lit00", $signed(C_o[0][0]), lit00);
      check("lit11", $signed(C_o[1][1]), lit11);
      check("model_lit00", exp_c[0][0], lit00);
    end
    finish_result(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    set_tile(1, 1, 127, 127);
    repeat (3) @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_c_o", C_o, 0);
    check("rst_sat", o_sat, 0);
    rst = 1'b0;

    run_tile(1'b0, 1'b1, 8, 8);
    set_tile(1, 1, 128, 127);
    run_tile(1'b0, 1'b1, 16, 16);
    set_tile(1, 1, 126, 127);
    run_tile(1'b0, 1'b1, 4, 4);
    set_tile(1, 1, 127, 127);
    for (int e = 0; e < N; e++) A[0][e] = 8'hFF;
    run_tile(1'b0, 1'b1, -8, 8);
    check("neg_row_c10", $signed(C_o[1][0]), 8);

    set_tile(1, 1, 127, 127);
    run_tile(1'b0, 1'b1, 8, 8);
    run_tile(1'b1, 1'b1, 16, 16);
    run_tile(1'b0, 1'b1, 8, 8);

    set_tile(127, 127, 131, 127);
    run_tile(1'b0, 1'b1, 32767, 32767);
    check("sat_hi_flags", o_sat, 4'hF);
    set_tile(-128, 127, 131, 127);
    run_tile(1'b0, 1'b1, -32768, -32768);
    check("sat_lo_flags", o_sat, 4'hF);

    set_tile(-1, 1, 0, 0);
    run_tile(1'b0, 1'b1, 0, 0);

    set_mixed(0);
    run_tile(1'b0, 1'b0, 0, 0);
    set_mixed(1);
    run_tile(1'b1, 1'b0, 0, 0);

    set_tile(1, 1, 127, 127);
    start_tile(1'b0);
    wait_result();
    set_tile(2, 1, 127, 127);
    i_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("bp_c_o", $signed(C_o[0][0]), 8);
    check("bp_ready", o_ready, 0);
    finish_result(0);
    start_tile(1'b0);
    wait_result();
    check("bp_second", $signed(C_o[0][0]), 16);
    finish_result(0);

    set_tile(1, 1, 127, 127);
    start_tile(1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    exp_ok = 1'b0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) macc[i][j] = 0;
    #1;
    check("abort_c_o", C_o, 0);
    check("abort_sat", o_sat, 0);
    check("abort_valid", o_valid, 0);
    check("abort_ready", o_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", o_ready, 1);
    run_tile(1'b1, 1'b1, 8, 8);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
